// File: rtl/pong_pkg.sv
// Shared pong definitions: game states, winner codes and screen geometry used by the
// ball, paddle and score blocks.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        PLAY = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int unsigned SCREEN_W = 640;

    // Ball x at or above this value is an underflow of the ball's 10-bit x decrement
    localparam logic [9:0] WRAP_BAND = 10'd960;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
// Used for the post-goal serve hold and reusable for paddle input debouncing.
module hold_timer #(
    parameter int unsigned MAX_COUNT = 120,
    localparam int unsigned W = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: detects goals from ball x, keeps both scores, holds the ball at serve
// after each goal and freezes play on a win. Define SCORE_WIN_BY_TWO_EN for win-by-two.
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned LEFT_GOAL_X  = 0,
    parameter int unsigned RIGHT_GOAL_X = 630,
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned HOLD_TICKS   = 120,
    parameter int unsigned SCORE_W      = 4
) (
    input  logic               game_clk,
    input  logic               rst,
    input  logic               start,
    input  logic [9:0]         ball_x,
    output logic               ball_rst,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               goal_pulse,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam int unsigned        HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [9:0]         LEFT_X    = 10'(LEFT_GOAL_X);
    localparam logic [9:0]         RIGHT_X   = 10'(RIGHT_GOAL_X);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic [1:0]         winner_q, winner_d;
    logic               ball_rst_q, ball_rst_d;
    logic               goal_q, goal_d;
    logic               over_q, over_d;

    logic               timer_load;
    logic               timer_done;
    logic               left_goal;
    logic               right_goal;
    logic               game_won;
    logic [1:0]         leader;

    hold_timer #(
        .MAX_COUNT (HOLD_TICKS)
    ) u_hold_timer (
        .clk      (game_clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (HOLD_LOAD),
        .done     (timer_done)
    );

    // Left goal wins ties so a misconfigured overlap still scores deterministically
    assign left_goal  = (ball_x <= LEFT_X) || (ball_x >= WRAP_BAND);
    assign right_goal = (ball_x >= RIGHT_X) && (ball_x < WRAP_BAND);

`ifdef SCORE_WIN_BY_TWO_EN
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [SCORE_W:0] p1_ext;
    logic [SCORE_W:0] p2_ext;
    logic             p1_at_max;
    logic             p2_at_max;
    logic             p1_lead_win;
    logic             p2_lead_win;

    assign p1_ext      = {1'b0, p1_q};
    assign p2_ext      = {1'b0, p2_q};
    assign p1_at_max   = (p1_q == SCORE_MAX);
    assign p2_at_max   = (p2_q == SCORE_MAX);
    assign p1_lead_win = (p1_q >= WIN_VAL) && (p1_ext >= p2_ext + (SCORE_W + 1)'(2));
    assign p2_lead_win = (p2_q >= WIN_VAL) && (p2_ext >= p1_ext + (SCORE_W + 1)'(2));
    assign game_won    = p1_at_max || p2_at_max || p1_lead_win || p2_lead_win;
    // A saturated score ends the game for its owner even without a two-point lead
    assign leader      = p1_at_max ? WIN_P1 :
                         p2_at_max ? WIN_P2 :
                         (p1_q > p2_q) ? WIN_P1 : WIN_P2;
`else
    assign game_won = (p1_q == WIN_VAL) || (p2_q == WIN_VAL);
    assign leader   = (p1_q == WIN_VAL) ? WIN_P1 : WIN_P2;
`endif

    always_comb begin
        state_d    = state_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        winner_d   = winner_q;
        goal_d     = 1'b0;
        timer_load = 1'b0;
        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d    = HOLD;
                    timer_load = 1'b1;
                    p1_d       = '0;
                    p2_d       = '0;
                    winner_d   = WIN_NONE;
                end
            end
            HOLD: begin
                if (timer_done) begin
                    if (game_won) begin
                        state_d  = OVER;
                        winner_d = leader;
                    end else begin
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                if (left_goal || right_goal) begin
                    state_d    = HOLD;
                    timer_load = 1'b1;
                    goal_d     = 1'b1;
                    if (left_goal) begin
                        p2_d = p2_q + 1'b1;
                    end else begin
                        p1_d = p1_q + 1'b1;
                    end
                end
            end
        endcase
        ball_rst_d = (state_d != PLAY);
        over_d     = (state_d == OVER);
    end

    always_ff @(posedge game_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            p1_q       <= '0;
            p2_q       <= '0;
            winner_q   <= WIN_NONE;
            ball_rst_q <= 1'b1;
            goal_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            winner_q   <= winner_d;
            ball_rst_q <= ball_rst_d;
            goal_q     <= goal_d;
            over_q     <= over_d;
        end
    end

    assign ball_rst   = ball_rst_q;
    assign p1_score   = p1_q;
    assign p2_score   = p2_q;
    assign goal_pulse = goal_q;
    assign game_over  = over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a game-level reference model predicts every cycle's
// outputs into a queue that a separate monitor drains and compares.
module tb_score_keeper;

    localparam int HOLD = 120;
    localparam int WIN  = 7;
    localparam int SMAX = 15;

    logic       game_clk = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic [9:0] ball_x   = 10'd320;
    logic       ball_rst;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       goal_pulse;
    logic       game_over;
    logic [1:0] winner;

    score_keeper dut (
        .game_clk   (game_clk),
        .rst        (rst),
        .start      (start),
        .ball_x     (ball_x),
        .ball_rst   (ball_rst),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .goal_pulse (goal_pulse),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 game_clk = ~game_clk;

    typedef struct {
        int ball_rst;
        int p1;
        int p2;
        int pulse;
        int over;
        int winner;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Game-level model: scores, remaining serve-hold ticks, whether the ball is live
    int m_p1, m_p2, m_hold, m_winner;
    bit m_play, m_over, m_pulse;

    function automatic bit won();
`ifdef SCORE_WIN_BY_TWO_EN
        int hi   = (m_p1 > m_p2) ? m_p1 : m_p2;
        int lead = (m_p1 > m_p2) ? m_p1 - m_p2 : m_p2 - m_p1;
        return (m_p1 == SMAX) || (m_p2 == SMAX) || (hi >= WIN && lead >= 2);
`else
        return (m_p1 == WIN) || (m_p2 == WIN);
`endif
    endfunction

    function automatic int lead_player();
        if (m_p1 == SMAX) return 1;
        if (m_p2 == SMAX) return 2;
        return (m_p1 > m_p2) ? 1 : 2;
    endfunction

    function automatic void model_step(bit s, bit r, int x);
        m_pulse = 0;
        if (r) begin
            m_p1 = 0; m_p2 = 0; m_hold = 0; m_winner = 0; m_play = 0; m_over = 0;
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                if (won()) begin
                    m_over   = 1;
                    m_winner = lead_player();
                end else begin
                    m_play = 1;
                end
            end
        end else if (m_play) begin
            if (x <= 0 || x >= 960) begin
                m_p2++; m_pulse = 1; m_play = 0; m_hold = HOLD;
            end else if (x >= 630) begin
                m_p1++; m_pulse = 1; m_play = 0; m_hold = HOLD;
            end
        end else if (s) begin
            m_p1 = 0; m_p2 = 0; m_winner = 0; m_over = 0; m_hold = HOLD;
        end
    endfunction

    task automatic cyc(bit s, bit r, int x);
        exp_t e;
        @(negedge game_clk);
        start  = s;
        rst    = r;
        ball_x = 10'(x);
        model_step(s, r, x);
        e.ball_rst = m_play ? 0 : 1;
        e.p1       = m_p1;
        e.p2       = m_p2;
        e.pulse    = m_pulse;
        e.over     = m_over;
        e.winner   = m_winner;
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 320);
    endtask

    // Serve out any hold, then put the ball at x for one live cycle
    task automatic play_goal(int x);
        int n = 0;
        while (!m_play && !m_over && n < 2000) begin
            cyc(0, 0, 320);
            n++;
        end
        if (m_play) cyc(0, 0, x);
    endtask

    task automatic chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    exp_t mon_e;
    always @(posedge game_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ball_rst", int'(ball_rst), mon_e.ball_rst);
            chk("p1_score", int'(p1_score), mon_e.p1);
            chk("p2_score", int'(p2_score), mon_e.p2);
            chk("goal_pulse", int'(goal_pulse), mon_e.pulse);
            chk("game_over", int'(game_over), mon_e.over);
            chk("winner", int'(winner), mon_e.winner);
        end
    end

    initial begin
        int x;
        repeat (3) cyc(0, 1, 320);

        // Start, full serve hold, then a right goal and an underflow left goal
        cyc(1, 0, 320);
        play_goal(630);
        cyc(1, 0, 320);
        play_goal(1023);
        idle(HOLD + 2);
        cyc(1, 0, 320);

        // Run player 1 to the winning score, sit in OVER, then restart
        for (int k = 0; k < 8; k++) play_goal(630 + k * 40);
        idle(HOLD + 5);
        cyc(1, 0, 320);

        // Reach 3/2 and reset partway through the following hold
        for (int k = 0; k < 3; k++) play_goal(700);
        play_goal(0);
        play_goal(980);
        idle(49);
        cyc(0, 1, 320);
        idle(5);

        // Alternate goals to 6-6, then two more for player 1
        cyc(1, 0, 320);
        for (int k = 0; k < 6; k++) begin
            play_goal(640);
            play_goal(0);
        end
        play_goal(630);
        play_goal(630);
        idle(HOLD + 5);

        // Random play with occasional starts and resets
        cyc(1, 0, 320);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) x = int'($urandom_range(0, 1023));
            else x = int'($urandom_range(1, 629));
            cyc(bit'($urandom_range(0, 199) == 0), bit'($urandom_range(0, 2499) == 0), x);
        end

        idle(2);
        @(negedge game_clk);
        chk("queue_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Downstream of the ball mover: watches ball x each game_clk tick, detects goals, updates both players' scores and drives the ball's synchronous reset.
- Holds the ball at its serve position for a fixed delay after each goal, and at game start.
- Freezes play when a player reaches the winning score.
- Sits between the ball mover and the display/score renderer. Its ball_rst output is ORed with the system rst at the ball's rst input.

Parameters:
- LEFT_GOAL_X, 0: ball_x at or below this value is a goal for player 2.
- RIGHT_GOAL_X, 630: ball_x at or above this value (and below WRAP_BAND) is a goal for player 1.
- WIN_SCORE, 7: score that ends the game.
- HOLD_TICKS, 120: number of game_clk cycles ball_rst is held after a goal or start; range 1..1023.
- SCORE_W, 4: score counter width.

Ports:
- game_clk  in  1  game tick clock.
- rst  in  1  reset: synchronous, active-high, on clock game_clk.
- start  in  1  one-cycle pulse that begins or restarts a game.
- ball_x  in  10  current ball x from the ball mover.
- ball_rst  out  1  registered; drives the ball's synchronous reset.
- p1_score  out  SCORE_W  player 1 score.
- p2_score  out  SCORE_W  player 2 score.
- goal_pulse  out  1  one-cycle pulse on each scored goal.
- game_over  out  1  high while in OVER.
- winner  out  2  0 = none, 1 = player 1, 2 = player 2.

Behaviour:
Reset (rst high at a clock edge, overrides everything, including mid-hold):
- state = IDLE, p1_score = p2_score = 0, ball_rst = 1, goal_pulse = 0, game_over = 0, winner = 0, hold counter = 0.

States:
- IDLE: ball_rst = 1. On start, go to HOLD with the counter loaded to HOLD_TICKS-1 and scores cleared.
- HOLD: ball_rst = 1. The counter decrements each cycle. When the counter is 0:
  - if either score equals WIN_SCORE, go to OVER;
  - else go to PLAY.
  - ball_rst is therefore high for exactly HOLD_TICKS cycles.
- PLAY: ball_rst = 0. Combinational goal compare on ball_x each cycle.
  - Left goal: ball_x <= LEFT_GOAL_X, or ball_x >= WRAP_BAND (960). The WRAP_BAND term catches the 10-bit underflow of the ball's x decrement.
  - Right goal: ball_x >= RIGHT_GOAL_X and ball_x < WRAP_BAND.
  - The left-goal check has priority if both conditions hold (misconfigured parameters).
  - On a goal at edge N, at edge N+1:
    - increment the scorer's score;
    - goal_pulse = 1 for one cycle;
    - ball_rst = 1;
    - state = HOLD, counter = HOLD_TICKS-1.
  - ball_x changes during the goal cycle are ignored.
- OVER: ball_rst = 1, game_over = 1, winner = leader (set on OVER entry, held until leaving OVER).
  - On start: clear scores, clear winner and game_over, go to HOLD.

Other rules:
- start is ignored in HOLD and PLAY.
- The first PLAY cycle always sees the ball at its serve position, so no false goal is possible.
- Scores never exceed WIN_SCORE in base mode.
- The goal compare is combinational; all outputs are registered.

Optional Feature:
- Macro: SCORE_WIN_BY_TWO_EN.
- Defined: the game ends only when a score is >= WIN_SCORE and leads by >= 2.
  - If an increment would make a score reach 2^SCORE_W-1, the game ends with that scorer as winner regardless of lead.
  - The HOLD-exit check uses this rule.
- Undefined: the game ends when the first score reaches WIN_SCORE; the lead is not checked.

Decomposition:
- Shared package pong_pkg holds:
  - state enum (IDLE, HOLD, PLAY, OVER);
  - WRAP_BAND = 960;
  - winner encodings (WIN_NONE = 0, WIN_P1 = 1, WIN_P2 = 2);
  - screen constants (SCREEN_W = 640) shared with the ball and paddle blocks.
- Sub-module hold_timer:
  - loadable down-counter, width $clog2(HOLD_TICKS+1);
  - inputs load and load value; output done, high when the count is 0;
  - also reusable for paddle input debouncing.

Test Plan:
- Reset, then start pulse -> ball_rst high for exactly 120 cycles after start, then 0; scores 0/0; state PLAY.
- In PLAY, drive ball_x = 630 -> next cycle p1_score = 1, goal_pulse high for one cycle, ball_rst = 1 for 120 cycles.
- In PLAY, drive ball_x = 1023 (underflow) -> p2_score increments; p1_score unchanged.
- p1_score = 6, then right goal -> p1_score = 7; after the hold, game_over = 1, winner = 1, ball_rst stays 1; a further start clears scores and goes to HOLD.
- rst asserted at hold cycle 50 with scores 3/2 -> next cycle all outputs at their reset values, state IDLE; start in PLAY has no effect.
- With SCORE_WIN_BY_TWO_EN defined, at 7-6 -> no game_over; then 8-6 -> game_over = 1, winner = 1.
